// File: rtl/ring_counter_gen_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ring_counter_gen_if : control/status bundle for ring_counter_gen |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface ring_counter_gen_if #(
  parameter int WIDTH = 8
);
  localparam int POS_W = $clog2(WIDTH);

  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [POS_W-1:0] pos;
  logic             wrap;
  logic             err;

  modport master (
    output en, dir, mode, load, load_val,
    input  count, pos, wrap, err
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output count, pos, wrap, err
  );
endinterface
`default_nettype wire

// File: rtl/ring_counter_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ring_counter_gen : ring / Johnson / bounce sequence generator    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module ring_counter_gen #(
  parameter int WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ring_counter_gen_if.slave bus
);
  localparam int               POS_W   = $clog2(WIDTH);
  localparam logic [1:0]       c_RING  = 2'b00;
  localparam logic [1:0]       c_JOHN  = 2'b01;
  localparam logic [1:0]       c_BNCE  = 2'b10;
  localparam logic [WIDTH-1:0] c_START = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             bdir_q, bdir_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             w_onehot;
  logic             w_fix;
  logic [POS_W-1:0] w_pos;

  assign w_onehot = (count_q != '0) && ((count_q & (count_q - c_START)) == '0);

  always_comb begin
    count_d = count_q;
    bdir_d  = bdir_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    w_fix   = 1'b0;
    if (bus.load) begin
      count_d = bus.load_val;
      bdir_d  = 1'b0;
    end else if (bus.en) begin
      case (bus.mode)
        c_RING: begin
          if (!w_onehot)     w_fix = 1'b1;
          else if (bus.dir)  count_d = {count_q[0], count_q[WIDTH-1:1]};
          else               count_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
        end
        c_JOHN: begin
          if (bus.dir) count_d = {~count_q[0], count_q[WIDTH-1:1]};
          else         count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
        end
        c_BNCE: begin
          // Turn around at either end; dir input plays no part here.
          if (!w_onehot) begin
            w_fix = 1'b1;
          end else if (!bdir_q && count_q[WIDTH-1]) begin
            count_d = count_q >> 1;
            bdir_d  = 1'b1;
          end else if (bdir_q && count_q[0]) begin
            count_d = count_q << 1;
            bdir_d  = 1'b0;
          end else if (bdir_q) begin
            count_d = count_q >> 1;
          end else begin
            count_d = count_q << 1;
          end
        end
        default: ;
      endcase
      if (w_fix) begin
        count_d = c_START;
        bdir_d  = 1'b0;
        err_d   = 1'b1;
      end else if (bus.mode != 2'b11 && count_d == c_START) begin
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= c_START;
      bdir_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      bdir_q  <= bdir_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    w_pos = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (count_q[i]) w_pos = POS_W'(i);
    end
  end

  assign bus.count = count_q;
  assign bus.pos   = w_pos;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_ring_counter_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ring_counter_gen : scoreboard bench for ring_counter_gen      |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_ring_counter_gen;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] count;
    logic [2:0]   pos;
    logic         wrap;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wrap_cnt = 0;
  int   err_cnt = 0;
  exp_t sb[$];

  logic [W-1:0] m_count = 8'h01;
  logic         m_bdir  = 1'b0;

  ring_counter_gen_if #(.WIDTH(W)) bus ();

  ring_counter_gen #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] low_pos(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic int idx_of(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return 0;
  endfunction

  // One clock: drive inputs, predict with the reference model, compare after the edge.
  task automatic step(input logic r, input logic l, input logic e, input logic d,
                      input logic [1:0] m, input logic [W-1:0] lv);
    exp_t         x;
    exp_t         got;
    logic [W-1:0] n;
    int           p;
    @(negedge clk);
    rst = r; bus.load = l; bus.en = e; bus.dir = d; bus.mode = m; bus.load_val = lv;
    x.wrap = 1'b0; x.err = 1'b0;
    n = m_count;
    if (r) begin
      n = 8'h01; m_bdir = 1'b0;
    end else if (l) begin
      n = lv; m_bdir = 1'b0;
    end else if (e && m != 2'b11) begin
      if (m != 2'b01 && $countones(m_count) != 1) begin
        n = 8'h01; m_bdir = 1'b0; x.err = 1'b1;
      end else begin
        case (m)
          2'b00: for (int i = 0; i < W; i++)
                   if (d) n[i] = m_count[(i + 1) % W];
                   else   n[(i + 1) % W] = m_count[i];
          2'b01: for (int i = 0; i < W; i++)
                   if (d) n[i] = (i == W - 1) ? ~m_count[0] : m_count[i + 1];
                   else   n[i] = (i == 0) ? ~m_count[W - 1] : m_count[i - 1];
          default: begin
            p = idx_of(m_count);
            if (!m_bdir) begin
              if (p == W - 1) begin p = W - 2; m_bdir = 1'b1; end else p++;
            end else begin
              if (p == 0) begin p = 1; m_bdir = 1'b0; end else p--;
            end
            n = '0; n[p] = 1'b1;
          end
        endcase
        x.wrap = (n == 8'h01);
      end
    end
    m_count = n;
    x.count = n;
    x.pos   = low_pos(n);
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("count", 32'(bus.count), 32'(got.count));
      chk("pos",   32'(bus.pos),   32'(got.pos));
      chk("wrap",  32'(bus.wrap),  32'(got.wrap));
      chk("err",   32'(bus.err),   32'(got.err));
      wrap_cnt += int'(bus.wrap);
      err_cnt  += int'(bus.err);
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.dir = 1'b0; bus.mode = 2'b00; bus.load = 1'b0; bus.load_val = '0;

    // Reset state
    step(1, 0, 0, 0, 2'b00, 8'h00);
    chk("reset_count", 32'(bus.count), 32'h01);

    // Ring left, 8 steps
    wrap_cnt = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 2'b00, 8'h00);
    chk("ring_left_end", 32'(bus.count), 32'h01);
    chk("ring_left_wraps", 32'(wrap_cnt), 32'd1);

    // Ring right with an idle gap
    wrap_cnt = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 2'b00, 8'h00);
    chk("ring_right_mid", 32'(bus.count), 32'h10);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 2'b00, 8'h00);
    step(0, 0, 1, 1, 2'b11, 8'h00);
    chk("hold_mode", 32'(bus.count), 32'h10);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 2'b00, 8'h00);
    chk("ring_right_end", 32'(bus.count), 32'h01);
    chk("ring_right_wraps", 32'(wrap_cnt), 32'd1);

    // Johnson left from 00
    step(0, 1, 0, 0, 2'b01, 8'h00);
    wrap_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 2'b01, 8'h00);
    chk("johnson_half", 32'(bus.count), 32'hFF);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 2'b01, 8'h00);
    chk("johnson_end", 32'(bus.count), 32'h00);
    chk("johnson_wraps", 32'(wrap_cnt), 32'd1);
    chk("johnson_errs", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 2'b01, 8'h00);

    // Bounce from reset, random dir
    step(1, 0, 0, 0, 2'b10, 8'h00);
    wrap_cnt = 0;
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1'($urandom_range(0, 1)), 2'b10, 8'h00);
    chk("bounce_top", 32'(bus.count), 32'h80);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1'($urandom_range(0, 1)), 2'b10, 8'h00);
    chk("bounce_end", 32'(bus.count), 32'h01);
    chk("bounce_wraps", 32'(wrap_cnt), 32'd1);

    // Self-correction in ring and bounce
    step(0, 1, 0, 0, 2'b00, 8'h5A);
    step(0, 0, 1, 0, 2'b00, 8'h00);
    chk("fix_ring_err", 32'(bus.err), 32'd1);
    chk("fix_ring_wrap", 32'(bus.wrap), 32'd0);
    step(0, 1, 0, 0, 2'b10, 8'h00);
    step(0, 0, 1, 0, 2'b10, 8'h00);
    chk("fix_bounce", 32'(bus.count), 32'h01);
    chk("fix_bounce_err", 32'(bus.err), 32'd1);

    // Priority checks
    step(1, 1, 1, 0, 2'b00, 8'h80);
    chk("rst_over_load", 32'(bus.count), 32'h01);
    step(0, 1, 1, 0, 2'b00, 8'h10);
    chk("load_over_en", 32'(bus.count), 32'h10);

    // Reset mid-bounce while heading right
    step(1, 0, 0, 0, 2'b10, 8'h00);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 2'b10, 8'h00);
    chk("bounce_rightward", 32'(bus.count), 32'h20);
    step(1, 0, 1, 0, 2'b10, 8'h00);
    step(0, 0, 1, 1, 2'b10, 8'h00);
    chk("bounce_after_rst", 32'(bus.count), 32'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ring_counter_gen.md
Name: ring_counter_gen

Overview:
Parametrised successor to the team's fixed 8-bit ring counter. Generates one-hot or twisted-ring (Johnson) sequences of configurable width, with enable, direction, bounce (ping-pong) mode, parallel load and illegal-state self-correction. Used as a sequencer and phase generator for scan and multiplexing blocks. Status outputs: wrap pulse, correction pulse and one-hot position index.

Parameters:
WIDTH, 8, counter width in bits; legal range 3..32.
POS_W, $clog2(WIDTH), width of the pos output; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  step enable; count advances one step per enabled cycle.
dir  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right); ignored in bounce mode.
mode  input  2  00 ring, 01 Johnson, 10 bounce, 11 hold.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value loaded when load=1.
count  output  WIDTH  counter state (registered).
pos  output  POS_W  index of lowest set bit of count; 0 when count==0 (combinational from count).
wrap  output  1  registered one-cycle pulse; count returned to start pattern.
err  output  1  registered one-cycle pulse; illegal state was corrected.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at rising edge): count = {WIDTH{1'b0}} | 1 (bit0 set); internal bounce direction bdir = 0 (left); wrap = 0; err = 0.
- Priority: rst > load > en. With rst=0 and load=1: count = load_val, bdir = 0, wrap = 0, err = 0. No legality check at load.
- en=0 or mode=11 (hold), with no load: count and bdir unchanged; wrap = 0; err = 0.
- Ring (mode 00), en=1:
  - Left: count = {count[W-2:0], count[W-1]}.
  - Right: count = {count[0], count[W-1:1]}.
  - Period W.
- Johnson (mode 01), en=1:
  - Left: count = {count[W-2:0], ~count[W-1]}.
  - Right: count = {~count[0], count[W-1:1]}.
  - Period 2W. No legality check; err stays 0.
- Bounce (mode 10), en=1: one-hot walks bit0 -> bit W-1 -> bit0 and repeats.
  - bdir=0 and count[W-1]=1: count = count >> 1, bdir = 1.
  - bdir=1 and count[0]=1: count = count << 1, bdir = 0.
  - Otherwise shift left if bdir=0, right if bdir=1.
  - Period 2W-2. dir is ignored.
- Self-correction (ring and bounce modes only): if en=1 and count is not exactly one-hot (popcount != 1), the step is replaced by count = 1, bdir = 0, and err pulses 1 on the following cycle. Switching mode from Johnson to ring or bounce while count is not one-hot is therefore corrected on the first enabled step.
- wrap: set to 1 for one cycle when an enabled step (not reset, not load, not correction) produces count == 1. Otherwise 0.
- Latency: one cycle from en/load/rst sampled to count update; wrap and err are aligned with the count update that caused them.
- Mode or dir changes take effect on the same edge they are sampled; no pipeline.
- Reset mid-sequence overrides everything; bdir is cleared.

Test Plan:
1. Reset, then ring, left, en=1 for 8 cycles (WIDTH=8) -> count 02,04,08,10,20,40,80,01; wrap=1 only in the cycle count becomes 01; pos steps 1..7,0.
2. Ring, right, en=1 from 01 -> 80,40,...,01 after 8 steps; toggle en=0 mid-run -> count holds and wrap stays 0.
3. Johnson, left, en=1 from 00 (via load) -> 01,03,07,0F,1F,3F,7F,FF,FE,FC,...,80,00; after 16 steps count is back at 00; wrap=1 once per period at count 01; err always 0.
4. Bounce from reset -> 02..80 then 40,20,...,01 (14-step period); wrap=1 at the return to 01; dir toggled randomly has no effect.
5. Load 8'h5A in ring mode, then en=1 -> count=01 next cycle with err=1 and wrap=0. Load 8'h00 in bounce mode, en=1 -> same correction.
6. Simultaneous rst=1, load=1, en=1 with load_val=8'h80 -> count=01. load=1 with en=1 and load_val=8'h10 -> count=10 (load wins). Assert rst mid-bounce while moving right -> count=01 and the next step goes left to 02.
